// File: rtl/apu_cluster_package.sv
// Shared APU cluster widths so marx and every shim agree.
// Only defaults live here; instances may override them.
package apu_cluster_package;

  localparam int WAPUTAG  = 2;
  localparam int NARGS    = 3;
  localparam int NUSFLAGS = 5;
  localparam int NDSFLAGS = 15;
  localparam int WOP      = 6;

endpackage

// File: rtl/apu_result_fifo.sv
// In-order result queue: circular buffer with occupancy counter.
// Pointers wrap at DEPTH, so DEPTH need not be a power of two.
module apu_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_ci,
  input  logic         rst_rbi,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CMAX);
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_ci or negedge rst_rbi) begin
    if (!rst_rbi) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= nxt(wr_ptr);
      if (rd_ok) rd_ptr <= nxt(rd_ptr);
      if (wr_ok & ~rd_ok)
        cnt <= cnt + CW'(1);
      else if (rd_ok & ~wr_ok)
        cnt <= cnt - CW'(1);
    end
  end

  // Payload storage needs no reset; empty gates the read port.
  always_ff @(posedge clk_ci) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/apu_pipe_shim.sv
// marx-side adapter for a fixed-latency, non-stallable APU datapath.
// Tags ride a shift pipe; credits keep the result queue from overflowing.
module apu_pipe_shim #(
  parameter int WOP      = apu_cluster_package::WOP,
  parameter int WAPUTAG  = apu_cluster_package::WAPUTAG,
  parameter int NARGS    = apu_cluster_package::NARGS,
  parameter int NUSFLAGS = apu_cluster_package::NUSFLAGS,
  parameter int NDSFLAGS = apu_cluster_package::NDSFLAGS,
  parameter int LATENCY  = 3,
  parameter int DEPTH    = 5
) (
  input  logic                  clk_ci,
  input  logic                  rst_rbi,
  input  logic                  valid_ds_s,
  output logic                  ready_ds_s,
  input  logic [NARGS*32-1:0]   operands_ds_d,
  input  logic [WOP-1:0]        op_ds_d,
  input  logic [NDSFLAGS-1:0]   flags_ds_d,
  input  logic [WAPUTAG-1:0]    tag_ds_d,
  output logic                  unit_en_o,
  output logic [NARGS*32-1:0]   unit_operands_o,
  output logic [WOP-1:0]        unit_op_o,
  output logic [NDSFLAGS-1:0]   unit_flags_o,
  input  logic [31:0]           unit_result_i,
  input  logic [NUSFLAGS-1:0]   unit_flags_i,
  output logic                  req_us_s,
  input  logic                  ack_us_s,
  output logic [31:0]           result_us_d,
  output logic [NUSFLAGS-1:0]   flags_us_d,
  output logic [WAPUTAG-1:0]    tag_us_d
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = 32 + NUSFLAGS + WAPUTAG;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [CW-1:0]      credit;
  logic               issue;
  logic               pop;
  logic [LATENCY-1:0] pipe_v;
  logic [WAPUTAG-1:0] pipe_tag [LATENCY];
  logic               q_empty;
  logic [QW-1:0]      q_rd;

  // Decoded from the credit register only: no path from valid/ack.
  assign ready_ds_s = (credit < CMAX);
  assign issue      = valid_ds_s & ready_ds_s;
  assign pop        = req_us_s & ack_us_s;

  assign unit_en_o       = issue;
  assign unit_operands_o = operands_ds_d;
  assign unit_op_o       = op_ds_d;
  assign unit_flags_o    = flags_ds_d;

  always_ff @(posedge clk_ci or negedge rst_rbi) begin
    if (!rst_rbi) begin
      credit <= '0;
    end else if (issue & ~pop) begin
      credit <= credit + CW'(1);
    end else if (pop & ~issue) begin
      credit <= credit - CW'(1);
    end
  end

  always_ff @(posedge clk_ci or negedge rst_rbi) begin
    if (!rst_rbi) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++)
        pipe_tag[i] <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_tag[0] <= tag_ds_d;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  apu_result_fifo #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_ci  (clk_ci),
    .rst_rbi (rst_rbi),
    .wr_en   (pipe_v[LATENCY-1]),
    .wr_data ({unit_result_i, unit_flags_i,
               pipe_tag[LATENCY-1]}),
    .rd_en   (pop),
    .rd_data (q_rd),
    .empty   (q_empty)
  );

  assign req_us_s = ~q_empty;
  assign {result_us_d, flags_us_d, tag_us_d} = q_rd;

endmodule

// File: tb/tb_apu_pipe_shim.sv
// Bench for apu_pipe_shim: vector table, hand sequences and random
// traffic checked against a queue-based reference of issued operations.
module tb_apu_pipe_shim;

  localparam int L = 3;
  localparam int D = 5;

  logic         clk_ci = 1'b0;
  logic         rst_rbi = 1'b0;
  logic         valid_ds_s = 1'b0;
  logic         ready_ds_s;
  logic [95:0]  operands_ds_d = '0;
  logic [5:0]   op_ds_d = '0;
  logic [14:0]  flags_ds_d = '0;
  logic [1:0]   tag_ds_d = '0;
  logic         unit_en_o;
  logic [95:0]  unit_operands_o;
  logic [5:0]   unit_op_o;
  logic [14:0]  unit_flags_o;
  logic [31:0]  unit_result_i = '0;
  logic [4:0]   unit_flags_i = '0;
  logic         req_us_s;
  logic         ack_us_s = 1'b0;
  logic [31:0]  result_us_d;
  logic [4:0]   flags_us_d;
  logic [1:0]   tag_us_d;

  always #5 clk_ci = ~clk_ci;

  apu_pipe_shim #(
    .LATENCY (L),
    .DEPTH   (D)
  ) dut (
    .clk_ci          (clk_ci),
    .rst_rbi         (rst_rbi),
    .valid_ds_s      (valid_ds_s),
    .ready_ds_s      (ready_ds_s),
    .operands_ds_d   (operands_ds_d),
    .op_ds_d         (op_ds_d),
    .flags_ds_d      (flags_ds_d),
    .tag_ds_d        (tag_ds_d),
    .unit_en_o       (unit_en_o),
    .unit_operands_o (unit_operands_o),
    .unit_op_o       (unit_op_o),
    .unit_flags_o    (unit_flags_o),
    .unit_result_i   (unit_result_i),
    .unit_flags_i    (unit_flags_i),
    .req_us_s        (req_us_s),
    .ack_us_s        (ack_us_s),
    .result_us_d     (result_us_d),
    .flags_us_d      (flags_us_d),
    .tag_us_d        (tag_us_d)
  );

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] res;
    logic [4:0]  fl;
    int          vis;
  } ent_t;

  typedef struct {
    logic        v;
    logic [1:0]  tg;
    logic        ak;
    logic [31:0] rs;
    logic        e_ready;
    logic        e_req;
    logic [31:0] e_res;
    logic [1:0]  e_tag;
  } vec_t;

  ent_t        mq[$];
  logic        sv   [16];
  logic [31:0] sres [16];
  logic [4:0]  sfl  [16];
  int          cyc;
  int          tests;
  int          fails;

  logic        o_ready;
  logic        o_req;
  logic        o_en;
  logic [31:0] o_res;
  logic [1:0]  o_tag;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_ready"}, 32'(ready_ds_s), 32'd1);
    chk({pfx, "_req"}, 32'(req_us_s), 32'd0);
    chk({pfx, "_en"}, 32'(unit_en_o), 32'd0);
    chk({pfx, "_result"}, result_us_d, 32'd0);
    chk({pfx, "_flags"}, 32'(flags_us_d), 32'd0);
    chk({pfx, "_tag"}, 32'(tag_us_d), 32'd0);
  endtask

  task automatic clear_model();
    mq.delete();
    for (int i = 0; i < 16; i++) sv[i] = 1'b0;
  endtask

  // One clock: drive just after posedge, check at negedge, advance model.
  task automatic cycle(input logic v, input logic [1:0] tg,
                       input logic ak, input logic [31:0] rs);
    int          s;
    int          sl;
    logic        ex_ready;
    logic        ex_req;
    logic        iss;
    logic        pp;
    ent_t        e;
    valid_ds_s    = v;
    tag_ds_d      = tg;
    ack_us_s      = ak;
    op_ds_d       = 6'($urandom);
    flags_ds_d    = 15'($urandom);
    operands_ds_d = {$urandom, $urandom, $urandom};
    s = cyc % 16;
    if (sv[s]) begin
      unit_result_i = sres[s];
      unit_flags_i  = sfl[s];
      sv[s] = 1'b0;
    end else begin
      unit_result_i = $urandom;
      unit_flags_i  = 5'($urandom);
    end
    @(negedge clk_ci);
    ex_ready = (mq.size() < D);
    ex_req   = (mq.size() > 0) && (mq[0].vis <= cyc);
    iss = v & ex_ready;
    pp  = ak & ex_req;
    o_ready = ready_ds_s;
    o_req   = req_us_s;
    o_en    = unit_en_o;
    o_res   = result_us_d;
    o_tag   = tag_us_d;
    chk("ready", 32'(ready_ds_s), 32'(ex_ready));
    chk("unit_en", 32'(unit_en_o), 32'(iss));
    chk("unit_op", 32'(unit_op_o), 32'(op_ds_d));
    chk("unit_flags", 32'(unit_flags_o), 32'(flags_ds_d));
    chk("unit_opnd", unit_operands_o[95:64], operands_ds_d[95:64]);
    chk("req", 32'(req_us_s), 32'(ex_req));
    if (ex_req) begin
      chk("head_result", result_us_d, mq[0].res);
      chk("head_tag", 32'(tag_us_d), 32'(mq[0].tag));
      chk("head_flags", 32'(flags_us_d), 32'(mq[0].fl));
    end else begin
      chk("idle_result", result_us_d, 32'd0);
    end
    if (dut.u_fifo.wr_en && dut.u_fifo.full) begin
      fails++;
      $display("FAIL overflow: queue written while full at cycle %0d", cyc);
    end
    if (pp) void'(mq.pop_front());
    if (iss) begin
      e.tag = tg;
      e.res = rs;
      e.fl  = 5'($urandom);
      e.vis = cyc + L + 1;
      mq.push_back(e);
      sl = (cyc + L) % 16;
      sv[sl]   = 1'b1;
      sres[sl] = rs;
      sfl[sl]  = e.fl;
    end
    @(posedge clk_ci);
    cyc++;
    #1;
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    int drops;
    int first;
    int run;
    int maxrun;
    tests = 0;
    fails = 0;
    cyc   = 0;
    clear_model();

    #2;
    chk_reset("por");
    @(negedge clk_ci);
    rst_rbi = 1'b1;
    @(posedge clk_ci);
    #1;

    // Single operation through the pipe.
    tbl[0] = '{1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 2'd0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0};
    tbl[2] = '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd2};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].tg, tbl[i].ak, tbl[i].rs);
      chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_req", i), 32'(o_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_res", i), o_res, tbl[i].e_res);
      chk($sformatf("tbl%0d_tag", i), 32'(o_tag), 32'(tbl[i].e_tag));
    end

    // Back-pressure: exactly DEPTH issues, then drain.
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'($urandom), 1'b0, $urandom);
      if (o_en) n++;
    end
    chk("bp_issues", 32'(n), 32'd5);
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    cycle(1'b0, 2'd0, 1'b1, 32'h0);
    chk("bp_first_pop_req", 32'(o_req), 32'd1);
    cycle(1'b0, 2'd0, 1'b1, 32'h0);
    chk("bp_ready_back", 32'(o_ready), 32'd1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 1'b1, 32'h0);
    chk("bp_drained", 32'(o_req), 32'd0);

    // Throughput with ack held high.
    n = 0;
    drops = 0;
    first = -1;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(i < 20, 2'($urandom), 1'b1, $urandom);
      if (o_en) n++;
      if (i < 20 && !o_ready) drops++;
      if (o_req) begin
        if (first < 0) first = i;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (i == 5)
        chk("tp_credit_steady", 32'(dut.credit), 32'd4);
    end
    chk("tp_issues", 32'(n), 32'd20);
    chk("tp_ready_drops", 32'(drops), 32'd0);
    chk("tp_first_req", 32'(first), 32'd4);
    chk("tp_req_run", 32'(maxrun), 32'd20);

    // Random traffic with ack stalls, exercising pointer wrap.
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 4) != 0, 2'($urandom),
            ($urandom % 3) != 0, $urandom);
      if (o_en) n++;
    end
    chk("rand_enough_issues", 32'(n >= 12), 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 2'd0, 1'b1, 32'h0);
    chk("rand_drained", 32'(o_req), 32'd0);

    // Reset with one queued and two in flight.
    cycle(1'b1, 2'd1, 1'b0, 32'h1111_0001);
    cycle(1'b0, 2'd0, 1'b0, 32'h0);
    cycle(1'b1, 2'd2, 1'b0, 32'h2222_0002);
    cycle(1'b1, 2'd3, 1'b0, 32'h3333_0003);
    cycle(1'b0, 2'd0, 1'b0, 32'h0);
    chk("mid_req_before", 32'(o_req), 32'd1);
    chk("mid_tag_before", 32'(o_tag), 32'd1);
    valid_ds_s = 1'b0;
    ack_us_s   = 1'b0;
    rst_rbi    = 1'b0;
    #1;
    chk_reset("mid");
    clear_model();
    @(negedge clk_ci);
    rst_rbi = 1'b1;
    @(posedge clk_ci);
    cyc++;
    #1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 2'd0, 1'b1, 32'h0);
      chk("post_rst_no_req", 32'(o_req), 32'd0);
    end
    cycle(1'b1, 2'd3, 1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
